// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the I-side fetch and D-side load/store requesters.
// Define ARB_ROUND_ROBIN_EN to alternate contested grants instead of fixed D priority.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   // I-side requester
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [MASK_WIDTH-1:0] i_rmask,
   output logic [DATA_WIDTH-1:0] i_rdata,
   output logic                  i_resp,
   // D-side requester
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [MASK_WIDTH-1:0] d_rmask,
   input  logic [MASK_WIDTH-1:0] d_wmask,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_resp,
   // memory port
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [MASK_WIDTH-1:0] mem_rmask,
   output logic [MASK_WIDTH-1:0] mem_wmask,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp,
   // debug view of the arbiter FSM: 0 = IDLE, 1 = BUSY, 2 = RESP
   output logic [1:0]            fsm_state
);

   // Handshake: a requester is pending while any of its masks is nonzero and must
   // hold addr/masks/wdata stable until it sees its one-cycle resp; it drops or
   // changes the request right after that resp. The memory answers each
   // transaction with exactly one mem_resp cycle while the masks are driven.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   logic   grant_d;
   logic   i_pend;
   logic   d_pend;
   logic   pick_d;

   assign i_pend = |i_rmask;
   assign d_pend = (|d_rmask) || (|d_wmask);

`ifdef ARB_ROUND_ROBIN_EN
   logic rr_ptr;  // 0: I-side wins the next contested grant, 1: D-side
   assign pick_d = d_pend && (!i_pend || rr_ptr);
`else
   assign pick_d = d_pend;
`endif

   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant_d   <= 1'b0;
         mem_addr  <= '0;
         mem_rmask <= '0;
         mem_wmask <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
         i_resp    <= 1'b0;
         d_resp    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         rr_ptr    <= 1'b0;
`endif
      end else begin
         i_resp <= 1'b0;
         d_resp <= 1'b0;
         case (state)
            IDLE: begin
               if (i_pend || d_pend) begin
                  grant_d <= pick_d;
                  state   <= BUSY;
                  if (pick_d) begin
                     mem_addr  <= d_addr;
                     mem_rmask <= d_rmask;
                     mem_wmask <= d_wmask;
                     mem_wdata <= d_wdata;
                  end else begin
                     // I-side never writes; mem_wdata keeps its last value
                     mem_addr  <= i_addr;
                     mem_rmask <= i_rmask;
                     mem_wmask <= '0;
                  end
`ifdef ARB_ROUND_ROBIN_EN
                  if (i_pend && d_pend) begin
                     rr_ptr <= ~rr_ptr;
                  end
`endif
               end
            end
            BUSY: begin
               if (mem_resp) begin
                  if (grant_d) begin
                     d_rdata <= mem_rdata;
                  end else begin
                     i_rdata <= mem_rdata;
                  end
                  d_resp    <= grant_d;
                  i_resp    <= ~grant_d;
                  mem_rmask <= '0;
                  mem_wmask <= '0;
                  state     <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed plan steps then randomized traffic against a
// transaction-level model; honours ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic [3:0]  i_rmask, d_rmask, d_wmask;
   logic        mem_resp;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic        i_resp, d_resp;
   logic [3:0]  mem_rmask, mem_wmask;
   logic [1:0]  fsm_state;

   int          n_pass  = 0;
   int          n_total = 0;
   bit          rr_turn_i;     // model: I-side owns the next contested grant
   logic [31:0] exp_i_rdata;
   logic [31:0] exp_d_rdata;
   bit          g;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .i_addr(i_addr), .i_rmask(i_rmask), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_addr(d_addr), .d_rmask(d_rmask), .d_wmask(d_wmask), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
      .fsm_state(fsm_state)
   );

   // clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      assert (obs === exp_v) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      rr_turn_i   = 1'b1;
      exp_i_rdata = '0;
      exp_d_rdata = '0;
   endtask

   // Grant rule: lone requester wins; contested goes to D or to the pointer side.
   task automatic model_pick(output bit g_d);
      bit ip, dp;
      ip = |i_rmask;
      dp = (|d_rmask) || (|d_wmask);
      if (ip && dp) begin
`ifdef ARB_ROUND_ROBIN_EN
         g_d       = !rr_turn_i;
         rr_turn_i = !rr_turn_i;
`else
         g_d = 1'b1;
`endif
      end else begin
         g_d = dp;
      end
   endtask

   task automatic new_req_i();
      i_addr  = $urandom & 32'hFFFF_FFFC;
      i_rmask = 4'($urandom_range(1, 15));
   endtask

   task automatic new_req_d();
      int kind;
      kind    = $urandom_range(0, 2);
      d_addr  = $urandom & 32'hFFFF_FFFC;
      d_wdata = $urandom;
      d_rmask = (kind != 1) ? 4'($urandom_range(1, 15)) : 4'h0;
      d_wmask = (kind != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
   endtask

   task automatic drop(input bit g_d);
      if (g_d) begin
         d_rmask = 4'h0;
         d_wmask = 4'h0;
      end else begin
         i_rmask = 4'h0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_i_resp"}, i_resp, 1'b0);
      chk({tag, "_d_resp"}, d_resp, 1'b0);
      chk({tag, "_i_rdata"}, i_rdata, 32'h0);
      chk({tag, "_d_rdata"}, d_rdata, 32'h0);
      chk({tag, "_mem_addr"}, mem_addr, 32'h0);
      chk({tag, "_mem_rmask"}, mem_rmask, 4'h0);
      chk({tag, "_mem_wmask"}, mem_wmask, 4'h0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      chk({tag, "_state"}, fsm_state, 2'd0);
   endtask

   // Called in an IDLE cycle with at least one request driven; returns in the RESP cycle.
   task automatic serve(input int lat, input logic [31:0] rd, input bit stray, output bit g_d);
      logic [31:0] ea, ew;
      logic [3:0]  er, ewm;
      model_pick(g_d);
      ea  = g_d ? d_addr : i_addr;
      er  = g_d ? d_rmask : i_rmask;
      ewm = g_d ? d_wmask : 4'h0;
      ew  = d_wdata;
      step();
      for (int k = 1; k <= lat; k++) begin
         mem_resp = 1'b0;
         chk("busy_addr", mem_addr, ea);
         chk("busy_rmask", mem_rmask, er);
         chk("busy_wmask", mem_wmask, ewm);
         if (g_d) chk("busy_wdata", mem_wdata, ew);
         chk("busy_no_resp", {i_resp, d_resp}, 2'b00);
         chk("busy_state", fsm_state, 2'd1);
         if (k == lat) begin
            mem_resp  = 1'b1;
            mem_rdata = rd;
         end
         step();
      end
      mem_resp  = stray;
      mem_rdata = $urandom;
      if (g_d) exp_d_rdata = rd;
      else     exp_i_rdata = rd;
      chk("resp_pulse", {i_resp, d_resp}, {!g_d, g_d});
      chk("resp_i_rdata", i_rdata, exp_i_rdata);
      chk("resp_d_rdata", d_rdata, exp_d_rdata);
      chk("resp_rmask", mem_rmask, 4'h0);
      chk("resp_wmask", mem_wmask, 4'h0);
      chk("resp_state", fsm_state, 2'd2);
   endtask

   // From the RESP cycle (requests already updated) into the following IDLE cycle.
   task automatic to_idle(input bit stray);
      step();
      chk("idle_no_resp", {i_resp, d_resp}, 2'b00);
      chk("idle_rmask", mem_rmask, 4'h0);
      chk("idle_wmask", mem_wmask, 4'h0);
      chk("idle_state", fsm_state, 2'd0);
      chk("idle_i_rdata", i_rdata, exp_i_rdata);
      chk("idle_d_rdata", d_rdata, exp_d_rdata);
      mem_resp = stray;
   endtask

   task automatic drain();
      while ((|i_rmask) || (|d_rmask) || (|d_wmask)) begin
         serve($urandom_range(1, 3), $urandom, 1'b0, g);
         drop(g);
         to_idle(1'b0);
      end
   endtask

   initial begin
      // reset with an I request already asserted
      mem_resp  = 1'b0;
      mem_rdata = 32'h0;
      i_addr    = 32'h6000_0000;
      i_rmask   = 4'hF;
      d_addr    = 32'h0;
      d_rmask   = 4'h0;
      d_wmask   = 4'h0;
      d_wdata   = 32'h0;
      rst       = 1'b1;
      model_reset();
      step();
      check_all_zero("rst_c1");
      step();
      check_all_zero("rst_c2");
      rst = 1'b0;

      // single I read, memory answers on the third BUSY cycle
      serve(3, 32'h0000_0013, 1'b0, g);
      chk("i_read_value", i_rdata, 32'h0000_0013);
      drop(g);
      to_idle(1'b0);

      // D write, stray mem_resp in RESP and IDLE
      d_addr  = 32'h6000_0100;
      d_wmask = 4'h3;
      d_wdata = 32'hDEAD_BEEF;
      serve(4, 32'h1234_5678, 1'b1, g);
      drop(g);
      to_idle(1'b1);
      step();
      chk("stray_idle_no_resp", {i_resp, d_resp}, 2'b00);
      chk("stray_idle_state", fsm_state, 2'd0);
      mem_resp = 1'b0;

      // contention, memory latency 1
      i_addr  = 32'h6000_0040;
      i_rmask = 4'hF;
      d_addr  = 32'h6000_0200;
      d_rmask = 4'hF;
      serve(1, 32'hAAAA_0001, 1'b0, g);
      drop(g);
      to_idle(1'b0);
      serve(1, 32'hBBBB_0002, 1'b0, g);
      drop(g);
      to_idle(1'b0);

      // four contested rounds from a fresh reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      model_reset();
      check_all_zero("rst_rr");
      new_req_i();
      new_req_d();
      for (int r = 0; r < 4; r++) begin
         serve(1, $urandom, 1'b0, g);
         if (g) new_req_d();
         else   new_req_i();
         to_idle(1'b0);
      end
      drain();

      // reset while BUSY, then a late mem_resp
      i_addr  = 32'h6000_0080;
      i_rmask = 4'hF;
      step();
      chk("midbusy_rmask", mem_rmask, 4'hF);
      rst = 1'b1;
      step();
      rst      = 1'b0;
      i_rmask  = 4'h0;
      mem_resp = 1'b1;
      model_reset();
      check_all_zero("midbusy_rst");
      step();
      mem_resp = 1'b0;
      chk("midbusy_late_no_resp", {i_resp, d_resp}, 2'b00);
      chk("midbusy_late_state", fsm_state, 2'd0);
      chk("midbusy_late_rmask", mem_rmask, 4'h0);
      step();
      chk("midbusy_after_no_resp", {i_resp, d_resp}, 2'b00);

      // randomized traffic
      for (int r = 0; r < 60; r++) begin
         if (!((|i_rmask) || (|d_rmask) || (|d_wmask))) begin
            if ($urandom_range(0, 2) == 0) begin
               mem_resp = 1'b1;
               step();
               mem_resp = 1'b0;
               chk("rand_idle_no_resp", {i_resp, d_resp}, 2'b00);
               chk("rand_idle_state", fsm_state, 2'd0);
            end
            if ($urandom_range(0, 1) == 1) new_req_i();
            if ($urandom_range(0, 1) == 1) new_req_d();
            if (!((|i_rmask) || (|d_rmask) || (|d_wmask))) new_req_d();
         end
         serve($urandom_range(1, 5), $urandom, 1'($urandom_range(0, 1)), g);
         if ($urandom_range(0, 1) == 1) begin
            if (g) new_req_d();
            else   new_req_i();
         end else begin
            drop(g);
         end
         if (g && !(|i_rmask) && $urandom_range(0, 1) == 1) new_req_i();
         if (!g && !((|d_rmask) || (|d_wmask)) && $urandom_range(0, 1) == 1) new_req_d();
         to_idle(1'($urandom_range(0, 1)));
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the pipeline's instruction-fetch requester (I-side) and load/store requester (D-side).
- Sits between the core's two mem_itf-style request ports and a single-ported memory model or cache.
- Captures one request at a time, holds it on the memory port until the memory responds, then returns a one-cycle response to the granted requester.
- Default policy is fixed D-side priority; round-robin is optional.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- MASK_WIDTH, DATA_WIDTH/8, byte-enable width (derived; do not override).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- i_addr  input  ADDR_WIDTH  I-side request address
- i_rmask  input  MASK_WIDTH  I-side read byte mask; nonzero = request
- i_rdata  output  DATA_WIDTH  I-side read data, valid with i_resp
- i_resp  output  1  I-side response pulse
- d_addr  input  ADDR_WIDTH  D-side request address
- d_rmask  input  MASK_WIDTH  D-side read byte mask
- d_wmask  input  MASK_WIDTH  D-side write byte mask
- d_wdata  input  DATA_WIDTH  D-side write data
- d_rdata  output  DATA_WIDTH  D-side read data, valid with d_resp
- d_resp  output  1  D-side response pulse
- mem_addr  output  ADDR_WIDTH  memory address
- mem_rmask  output  MASK_WIDTH  memory read mask
- mem_wmask  output  MASK_WIDTH  memory write mask
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_rdata  input  DATA_WIDTH  memory read data
- mem_resp  input  1  memory response, one cycle per transaction

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; all mem_* outputs 0; i_resp=d_resp=0; i_rdata=d_rdata=0; round-robin pointer=I-side.
- Request present: I pending = |i_rmask. D pending = |d_rmask or |d_wmask.
- Requester contract: hold addr, masks and wdata stable from assertion until the cycle its resp is seen. Drop or change the request in the cycle after the resp.
- IDLE state:
  - No pending request: stay in IDLE.
  - One pending request: grant it.
  - Both pending: grant D (fixed priority).
  - On grant: register addr, rmask, wmask and wdata into capture registers; record the granted side; go to BUSY.
  - I-side wmask is always 0.
- BUSY state:
  - mem_* outputs drive the capture registers, held constant for every BUSY cycle.
  - On mem_resp=1: register mem_rdata into the granted side's rdata register; clear mem_rmask and mem_wmask in the same edge; go to RESP.
- RESP state:
  - Granted side's resp=1 for exactly one cycle, with its rdata valid.
  - The other side's resp stays 0.
  - All requests are ignored this cycle.
  - Next state is IDLE.
- rdata registers retain their last value after resp drops.
- Latency: request seen in cycle 0 → mem_* valid in cycle 1 → mem_resp in cycle N≥1 → requester resp in cycle N+1. Minimum turnaround is 3 cycles per transaction; no pipelining; one outstanding transaction maximum.
- Idle mem_* outputs: masks are 0 in IDLE and RESP. mem_addr and mem_wdata hold their last value.
- Ignored mem_resp: mem_resp in IDLE or RESP is ignored and must not cause a resp pulse.
- D-side with both rmask and wmask nonzero: forwarded unchanged. Memory semantics apply.
- Reset mid-transaction: on rst in any state, return to IDLE next cycle with reset output values. A pending resp is dropped; a mem_resp arriving afterwards is ignored.
- Back-to-back: a request still asserted in IDLE after RESP is treated as a new request. Requesters must comply with the drop-after-resp contract.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both sides are pending in IDLE, grant the side indicated by a 1-bit pointer, then set the pointer to the other side. The pointer updates only on contested grants. A single pending side is granted without changing the pointer.
- Undefined: fixed D-side priority and no pointer register; I-side can starve under continuous D traffic.

Test Plan:
- Reset then idle: assert rst 2 cycles with i_rmask=4'hF → all outputs 0, no mem request until rst low. First mem_rmask=4'hF one cycle after release.
- Single I read: i_addr=32'h6000_0000, i_rmask=4'hF; memory responds 3 cycles later with 32'h0000_0013 → i_resp=1 for one cycle with i_rdata=32'h0000_0013. d_resp stays 0.
- D write: d_addr=32'h6000_0100, d_wmask=4'h3, d_wdata=32'hDEAD_BEEF → mem_wmask=4'h3 and mem_wdata=32'hDEAD_BEEF held until mem_resp. d_resp pulses once.
- Contention, macro undefined: I and D both request in the same cycle, memory latency 1 → D served first (d_resp), then I (i_resp) 3 cycles later.
- Contention, ARB_ROUND_ROBIN_EN defined: 4 consecutive contested rounds → grant order I, D, I, D.
- Reset mid-BUSY: assert rst while mem_rmask=4'hF, then pulse mem_resp → no resp pulse on either side; state is IDLE; mem_rmask=0.
